// File: rtl/instr_cache_if.sv
// Fetch-port and instruction-memory signals of the instruction cache.
// The cache uses the slave modport; the CPU/memory environment uses master.
interface instr_cache_if;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );

  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
  );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: 8 blocks x 4 words x 32 bits.
// Hits are combinational; misses stall via BUSYWAIT while a block is fetched.
module instr_cache (
  input  logic          CLK,
  input  logic          RESET,
  instr_cache_if.slave  bus
);
  typedef enum logic {IDLE, FETCH} state_t;

  state_t       state_q, state_d;
  logic [7:0]   valid_q, valid_d;
  logic         mem_read_q, mem_read_d;
  logic [5:0]   mem_addr_q, mem_addr_d;
  logic [2:0]   tag_q  [8];
  logic [127:0] data_q [8];

  logic [1:0] pc_offset;
  logic [2:0] pc_index;
  logic [2:0] pc_tag;
  logic       hit;
  logic       fill_we;
  logic       unused_pc_bits;

  assign pc_offset      = bus.PC[3:2];
  assign pc_index       = bus.PC[6:4];
  assign pc_tag         = bus.PC[9:7];
  assign unused_pc_bits = ^{bus.PC[31:10], bus.PC[1:0]};

  always_comb begin
    hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    state_d    = state_q;
    valid_d    = valid_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    fill_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d    = FETCH;
          mem_read_d = 1'b1;
          mem_addr_d = {pc_tag, pc_index};
        end
      end
      FETCH: begin
        // Fill targets the latched address, so a PC change mid-fetch is harmless.
        if (!bus.MEM_BUSYWAIT) begin
          fill_we                  = 1'b1;
          valid_d[mem_addr_q[2:0]] = 1'b1;
          state_d                  = IDLE;
          mem_read_d               = 1'b0;
          mem_addr_d               = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.MEM_READ    = mem_read_q;
    bus.MEM_ADDRESS = mem_addr_q;
    // Valid bits clear asynchronously, so hit is already low under reset.
    bus.BUSYWAIT    = !RESET && ((state_q == FETCH) || !hit);
    bus.INSTRUCTION = '0;
    if (state_q == IDLE && hit)
      bus.INSTRUCTION = data_q[pc_index][{pc_offset, 5'b0} +: 32];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Reset forces state to IDLE, which keeps fill_we low and aborts any fill.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      data_q[mem_addr_q[2:0]] <= bus.MEM_READDATA;
      tag_q[mem_addr_q[2:0]]  <= mem_addr_q[5:3];
    end
  end
endmodule

// File: tb/tb_instr_cache.sv
// Directed self-checking bench for instr_cache with a latency-5 block memory.
module tb_instr_cache;
  logic CLK;
  logic RESET;
  int   n_tests;
  int   n_fail;
  int   lat_cnt;
  logic [31:0] mem_w [256];

  instr_cache_if bus ();

  instr_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory responder: data valid on the 5th cycle MEM_READ is held.
  always @(posedge CLK) lat_cnt <= bus.MEM_READ ? lat_cnt + 1 : 0;
  assign bus.MEM_BUSYWAIT = bus.MEM_READ && (lat_cnt != 4);
  assign bus.MEM_READDATA = {mem_w[{bus.MEM_ADDRESS, 2'd3}], mem_w[{bus.MEM_ADDRESS, 2'd2}],
                             mem_w[{bus.MEM_ADDRESS, 2'd1}], mem_w[{bus.MEM_ADDRESS, 2'd0}]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_until_ready(output int cycles, output logic [5:0] first_a,
                                 output logic [5:0] last_a);
    bit saw;
    cycles  = 0;
    saw     = 0;
    first_a = '0;
    last_a  = '0;
    while (bus.BUSYWAIT && cycles < 64) begin
      if (bus.MEM_READ) begin
        if (!saw) first_a = bus.MEM_ADDRESS;
        last_a = bus.MEM_ADDRESS;
        saw    = 1;
      end
      @(negedge CLK);
      #1;
      cycles++;
    end
  endtask

  // Caller aligns to a negedge first; PC is applied immediately.
  task automatic fetch(input string tag, input logic [31:0] pc, input int exp_stall,
                       input logic [5:0] exp_addr, input logic [31:0] exp_instr);
    int cycles;
    logic [5:0] fa, la;
    bus.PC = pc;
    #1;
    run_until_ready(cycles, fa, la);
    check_eq({tag, "_stall"}, cycles, exp_stall);
    if (exp_stall != 0) check_eq({tag, "_maddr"}, {26'd0, la}, {26'd0, exp_addr});
    else                check_eq({tag, "_idle_maddr"}, {26'd0, bus.MEM_ADDRESS}, 32'd0);
    check_eq({tag, "_instr"}, bus.INSTRUCTION, exp_instr);
  endtask

  initial begin
    int cycles;
    logic [5:0] fa, la;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 256; i++) mem_w[i] = 32'hC0DE_0000 + i;
    mem_w[0] = 32'h0004_0005;
    mem_w[1] = 32'h0002_0005;
    mem_w[2] = 32'h0206_0402;
    mem_w[3] = 32'h0101_0400;

    // Reset state
    RESET  = 1'b1;
    bus.PC = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    check_eq("rst_busy",  {31'd0, bus.BUSYWAIT}, 32'd0);
    check_eq("rst_mread", {31'd0, bus.MEM_READ}, 32'd0);
    check_eq("rst_maddr", {26'd0, bus.MEM_ADDRESS}, 32'd0);
    check_eq("rst_instr", bus.INSTRUCTION, 32'd0);

    // Cold miss after release, then sequential hits
    @(negedge CLK);
    RESET = 1'b0;
    fetch("cold0", 32'h000, 6, 6'h00, 32'h0004_0005);
    @(negedge CLK); fetch("hit4",  32'h004, 0, 6'h00, 32'h0002_0005);
    @(negedge CLK); fetch("hit8",  32'h008, 0, 6'h00, 32'h0206_0402);
    @(negedge CLK); fetch("hitc",  32'h00C, 0, 6'h00, 32'h0101_0400);

    // Conflict misses on index 0
    @(negedge CLK); fetch("conf80", 32'h080, 6, 6'h08, 32'hC0DE_0020);
    @(negedge CLK); fetch("conf00", 32'h000, 6, 6'h00, 32'h0004_0005);

    // Address boundaries
    @(negedge CLK); fetch("top3fc",  32'h3FC, 6, 6'h3F, 32'hC0DE_00FF);
    @(negedge CLK); fetch("top3f0",  32'h3F0, 0, 6'h00, 32'hC0DE_00FC);
    @(negedge CLK); fetch("wrap400", 32'h400, 0, 6'h00, 32'h0004_0005);
    @(negedge CLK); fetch("hiaddr",  32'hFFFF_FC04, 0, 6'h00, 32'h0002_0005);

    // Reset at FETCH cycle 2
    @(negedge CLK);
    bus.PC = 32'h080;
    #1;
    check_eq("mf_miss_busy", {31'd0, bus.BUSYWAIT}, 32'd1);
    @(negedge CLK); #1;
    check_eq("mf_fetch_mread", {31'd0, bus.MEM_READ}, 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_eq("mf_rst_mread", {31'd0, bus.MEM_READ}, 32'd0);
    check_eq("mf_rst_busy",  {31'd0, bus.BUSYWAIT}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    fetch("mf_after0", 32'h000, 6, 6'h00, 32'h0004_0005);
    @(negedge CLK); fetch("mf_after80", 32'h080, 6, 6'h08, 32'hC0DE_0020);

    // PC changed while in FETCH
    @(negedge CLK);
    bus.PC = 32'h000;
    #1;
    check_eq("pert_miss", {31'd0, bus.BUSYWAIT}, 32'd1);
    @(negedge CLK);
    bus.PC = 32'h010;
    #1;
    run_until_ready(cycles, fa, la);
    check_eq("pert_stall", cycles + 1, 32'd12);
    check_eq("pert_first_maddr", {26'd0, fa}, 32'h00);
    check_eq("pert_last_maddr",  {26'd0, la}, 32'h01);
    check_eq("pert_instr", bus.INSTRUCTION, 32'hC0DE_0004);
    @(negedge CLK); fetch("pert_hit0",  32'h000, 0, 6'h00, 32'h0004_0005);
    @(negedge CLK); fetch("pert_hit1c", 32'h01C, 0, 6'h00, 32'hC0DE_0007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
